gshare_pred: RTL and testbench

- Parametrised direction predictor in the fetch stage of the RISC-V core; next generation of the 5-bit global-history predictor.
- Adds configurable history and table depth, and selectable indexing (global / gshare / bimodal).
- Adds a multi-cycle table-initialisation FSM with a ready flag, and an index-tagged resolve interface so updates hit the entry actually used for the prediction.
- Sits between the fetch PC mux (consumes pc/imm/opcode) and the execute-stage branch resolver (produces updates).

---
 rtl/gshare_pred_pkg.sv | 23 ++
 rtl/gshare_pred_sat_ctr2.sv | 22 ++
 rtl/gshare_pred.sv | 139 +++++++++++++
 tb/tb_gshare_pred.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_pred_pkg.sv
// Shared constants for the fetch-stage direction predictor: opcodes, index modes,
// two-bit counter encodings and the table-initialisation state type.
package gshare_pred_pkg;

    localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
    localparam logic [4:0] OPC_JALR_5   = 5'b11001;
    localparam logic [4:0] OPC_JAL_5    = 5'b11011;

    localparam int MODE_GLOBAL  = 0;
    localparam int MODE_GSHARE  = 1;
    localparam int MODE_BIMODAL = 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gshare_pred_sat_ctr2.sv
// Two-bit saturating counter next-value function, shared by direction tables
// and BTB hysteresis.
module sat_ctr2
    import gshare_pred_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != CTR_ST) begin
                o_next = i_cur + 2'd1;
            end
        end else if (i_cur != CTR_SNT) begin
            o_next = i_cur - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_pred.sv
// Parametrised branch direction predictor (global / gshare / bimodal indexing)
// with a power-up table sweep and index-tagged, non-speculative updates.
module gshare_pred
    import gshare_pred_pkg::*;
#(
    parameter int         HIST_W   = 5,
    parameter int         IDX_W    = 5,
    parameter int         MODE     = MODE_GSHARE,
    parameter logic [1:0] INIT_CTR = CTR_WNT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic [4:0]       i_opc5,
    output logic             o_predict,
    output logic [31:0]      o_target,
    output logic [IDX_W-1:0] o_pred_idx,
    output logic             o_ready,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_initPtr;
    logic [HIST_W-1:0] r_ghr;
    logic [HIST_W-1:0] w_ghrNext;
    logic              r_ready;
    logic [1:0]        r_table [DEPTH];

    logic [IDX_W-1:0]  w_ghrIdx;
    logic [IDX_W-1:0]  w_pcIdx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_rdTaken;
    logic [1:0]        w_updCtr;
    logic [1:0]        w_updNext;
    logic              w_we;
    logic [IDX_W-1:0]  w_wAddr;
    logic [1:0]        w_wData;
    logic              w_ghrShift;

    // History is resized to the index width: zero-extended when short, low bits when long.
    generate
        if (HIST_W >= IDX_W) begin : g_ghrTrunc
            assign w_ghrIdx = r_ghr[IDX_W-1:0];
        end else begin : g_ghrExt
            assign w_ghrIdx = {{(IDX_W-HIST_W){1'b0}}, r_ghr};
        end

        if (HIST_W == 1) begin : g_ghrOne
            assign w_ghrNext = i_upd_taken;
        end else begin : g_ghrMany
            assign w_ghrNext = {r_ghr[HIST_W-2:0], i_upd_taken};
        end

        if (MODE == MODE_GLOBAL) begin : g_idxGlobal
            assign w_idx = w_ghrIdx;
        end else if (MODE == MODE_GSHARE) begin : g_idxGshare
            assign w_idx = w_pcIdx ^ w_ghrIdx;
        end else begin : g_idxBimodal
            assign w_idx = w_pcIdx;
        end
    endgenerate

    assign w_pcIdx   = i_pc[IDX_W+1:2];
    assign w_rdTaken = r_table[w_idx][1];
    assign w_updCtr  = r_table[i_upd_idx];

    sat_ctr2 u_satCtr (
        .i_cur   (w_updCtr),
        .i_taken (i_upd_taken),
        .o_next  (w_updNext)
    );

    // Single write port: the init sweep owns it in INIT, resolves use it in RUN.
    always_comb begin
        w_nextState = r_state;
        w_we        = 1'b0;
        w_wAddr     = i_upd_idx;
        w_wData     = w_updNext;
        w_ghrShift  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_we    = 1'b1;
                w_wAddr = r_initPtr;
                w_wData = INIT_CTR;
                if (r_initPtr == LAST_IDX) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_upd_valid) begin
                    w_we       = 1'b1;
                    w_ghrShift = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_INIT;
            r_initPtr <= '0;
            r_ghr     <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState == ST_RUN);
            if (r_state == ST_INIT) begin
                r_initPtr <= r_initPtr + 1'b1;
            end
            if (w_ghrShift) begin
                r_ghr <= w_ghrNext;
            end
        end
    end

    // Table contents survive reset; only the sweep that follows rewrites them.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_we) begin
            r_table[w_wAddr] <= w_wData;
        end
    end

    assign o_predict  = (i_opc5 == OPC_JAL_5) ||
                        ((i_opc5 == OPC_BRANCH_5) && r_ready && w_rdTaken);
    assign o_target   = i_pc + i_imm;
    assign o_pred_idx = w_idx;
    assign o_ready    = r_ready;

endmodule

// File: tb/tb_gshare_pred.sv
// Self-checking bench: three predictor instances (global, gshare, bimodal) share
// stimulus and are compared every cycle against a table/history reference model.
module tb_gshare_pred;
    import gshare_pred_pkg::*;

    localparam int HIST_W = 5;
    localparam int IDX_W  = 5;
    localparam int DEPTH  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  opc5;
    logic        updValid;
    logic [4:0]  updIdx;
    logic        updTaken;

    logic        predArr [3];
    logic [31:0] tgtArr  [3];
    logic [4:0]  idxArr  [3];
    logic        rdyArr  [3];

    int numChecks = 0;
    int numFails  = 0;

    int mTable [DEPTH];
    int mGhr;
    int mPtr;
    bit mReady;

    always #5 clk = ~clk;

    gshare_pred #(.HIST_W(HIST_W), .IDX_W(IDX_W), .MODE(0), .INIT_CTR(2'b01)) dutGlobal (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_imm(imm), .i_opc5(opc5),
        .o_predict(predArr[0]), .o_target(tgtArr[0]), .o_pred_idx(idxArr[0]), .o_ready(rdyArr[0]),
        .i_upd_valid(updValid), .i_upd_idx(updIdx), .i_upd_taken(updTaken)
    );

    gshare_pred #(.HIST_W(HIST_W), .IDX_W(IDX_W), .MODE(1), .INIT_CTR(2'b01)) dutGshare (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_imm(imm), .i_opc5(opc5),
        .o_predict(predArr[1]), .o_target(tgtArr[1]), .o_pred_idx(idxArr[1]), .o_ready(rdyArr[1]),
        .i_upd_valid(updValid), .i_upd_idx(updIdx), .i_upd_taken(updTaken)
    );

    gshare_pred #(.HIST_W(HIST_W), .IDX_W(IDX_W), .MODE(2), .INIT_CTR(2'b01)) dutBimodal (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_imm(imm), .i_opc5(opc5),
        .o_predict(predArr[2]), .o_target(tgtArr[2]), .o_pred_idx(idxArr[2]), .o_ready(rdyArr[2]),
        .i_upd_valid(updValid), .i_upd_idx(updIdx), .i_upd_taken(updTaken)
    );

    // Reference model advance for one clock edge using the inputs present at that edge.
    task automatic modelEdge();
        int cur;
        if (!rst) begin
            mPtr   = 0;
            mReady = 1'b0;
            mGhr   = 0;
        end else if (!mReady) begin
            mTable[mPtr] = 1;
            mPtr++;
            if (mPtr == DEPTH) mReady = 1'b1;
        end else if (updValid) begin
            mGhr = ((mGhr * 2) + (updTaken ? 1 : 0)) % (1 << HIST_W);
            cur  = mTable[int'(updIdx)];
            if (updTaken) mTable[int'(updIdx)] = (cur >= 3) ? 3 : cur + 1;
            else          mTable[int'(updIdx)] = (cur <= 0) ? 0 : cur - 1;
        end
    endtask

    function automatic logic [4:0] expIdx(int mode);
        int pcIdx;
        int ghrIdx;
        pcIdx  = int'(pc / 4) % DEPTH;
        ghrIdx = mGhr % DEPTH;
        if (mode == 0) return 5'(ghrIdx);
        if (mode == 1) return 5'(pcIdx ^ ghrIdx);
        return 5'(pcIdx);
    endfunction

    function automatic logic expPredict(int mode);
        if (opc5 == OPC_JAL_5) return 1'b1;
        if (opc5 == OPC_BRANCH_5 && mReady) return mTable[int'(expIdx(mode))] >= 2;
        return 1'b0;
    endfunction

    function automatic logic [31:0] expTarget();
        longint sum;
        sum = longint'(pc) + longint'(imm);
        return 32'(sum % 64'h1_0000_0000);
    endfunction

    task automatic applyStimulus(input logic [31:0] newPc, input logic [31:0] newImm,
                                 input logic [4:0] newOpc, input logic newValid,
                                 input logic [4:0] newIdx, input logic newTaken);
        pc       = newPc;
        imm      = newImm;
        opc5     = newOpc;
        updValid = newValid;
        updIdx   = newIdx;
        updTaken = newTaken;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        int cycles;
        $display("[TB] test_reset");
        rst = 1'b0;
        applyStimulus(32'h100, 32'h20, OPC_JAL_5, 1'b0, 5'd0, 1'b0);
        repeat (3) begin
            stepClock();
            for (int m = 0; m < 3; m++) begin
                numChecks++;
                if (rdyArr[m] !== 1'b0) begin
                    numFails++;
                    $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", m, rdyArr[m]);
                end
                numChecks++;
                if (predArr[m] !== 1'b1 || tgtArr[m] !== 32'h120) begin
                    numFails++;
                    $display("[TB] FAIL reset_jal[%0d]: got %b/%h expected 1/00000120", m, predArr[m], tgtArr[m]);
                end
            end
        end
        rst    = 1'b1;
        cycles = 0;
        while (rdyArr[1] !== 1'b1 && cycles < 100) begin
            applyStimulus(32'h100, 32'h20, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
            for (int m = 0; m < 3; m++) begin
                numChecks++;
                if (predArr[m] !== 1'b0 || rdyArr[m] !== mReady) begin
                    numFails++;
                    $display("[TB] FAIL init_branch[%0d]: got pred %b ready %b expected 0/%b", m, predArr[m], rdyArr[m], mReady);
                end
            end
            applyStimulus(32'h100, 32'h20, OPC_JAL_5, 1'b0, 5'd0, 1'b0);
            numChecks++;
            if (predArr[1] !== 1'b1 || tgtArr[1] !== 32'h120) begin
                numFails++;
                $display("[TB] FAIL init_jal: got %b/%h expected 1/00000120", predArr[1], tgtArr[1]);
            end
            stepClock();
            cycles++;
        end
        numChecks++;
        if (cycles != 32) begin
            numFails++;
            $display("[TB] FAIL init_length: got %0d cycles expected 32", cycles);
        end
        applyStimulus(32'h100, 32'h20, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
        for (int m = 0; m < 3; m++) begin
            numChecks++;
            if (predArr[m] !== 1'b0 || rdyArr[m] !== 1'b1) begin
                numFails++;
                $display("[TB] FAIL post_init_branch[%0d]: got pred %b ready %b expected 0/1", m, predArr[m], rdyArr[m]);
            end
        end
    endtask

    task automatic test_saturation();
        bit takenSeq [6] = '{1, 1, 1, 1, 0, 0};
        bit expSeq   [6] = '{1, 1, 1, 1, 1, 0};
        $display("[TB] test_saturation");
        applyStimulus(32'h40, 32'h0, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
        numChecks++;
        if (idxArr[2] !== 5'h10 || predArr[2] !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL sat_start: got idx %h pred %b expected 10/0", idxArr[2], predArr[2]);
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(32'h40, 32'h0, OPC_BRANCH_5, 1'b1, 5'h10, takenSeq[k]);
            stepClock();
            applyStimulus(32'h40, 32'h0, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
            numChecks++;
            if (predArr[2] !== expSeq[k]) begin
                numFails++;
                $display("[TB] FAIL sat_step%0d: got %b expected %b", k, predArr[2], expSeq[k]);
            end
            for (int m = 0; m < 3; m++) begin
                numChecks++;
                if (predArr[m] !== expPredict(m)) begin
                    numFails++;
                    $display("[TB] FAIL sat_model[%0d]: got %b expected %b", m, predArr[m], expPredict(m));
                end
            end
        end
    endtask

    task automatic test_gshare_index();
        bit histSeq [5] = '{0, 0, 1, 0, 1};
        $display("[TB] test_gshare_index");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(32'h0, 32'h0, OPC_JALR_5, 1'b1, 5'd0, histSeq[k]);
            stepClock();
        end
        applyStimulus(32'h58, 32'h0, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
        numChecks++;
        if (idxArr[1] !== 5'b10011) begin
            numFails++;
            $display("[TB] FAIL gshare_idx: got %b expected 10011", idxArr[1]);
        end
        numChecks++;
        if (idxArr[0] !== 5'b00101 || idxArr[2] !== 5'b10110) begin
            numFails++;
            $display("[TB] FAIL global_bimodal_idx: got %b/%b expected 00101/10110", idxArr[0], idxArr[2]);
        end
    endtask

    task automatic test_same_cycle();
        $display("[TB] test_same_cycle");
        applyStimulus(32'h0C, 32'h0, OPC_BRANCH_5, 1'b1, 5'd3, 1'b1);
        numChecks++;
        if (predArr[2] !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL hazard_same: got %b expected 0", predArr[2]);
        end
        for (int m = 0; m < 2; m++) begin
            numChecks++;
            if (idxArr[m] !== expIdx(m)) begin
                numFails++;
                $display("[TB] FAIL hazard_idx[%0d]: got %h expected %h", m, idxArr[m], expIdx(m));
            end
        end
        stepClock();
        applyStimulus(32'h0C, 32'h0, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
        numChecks++;
        if (predArr[2] !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL hazard_next: got %b expected 1", predArr[2]);
        end
    endtask

    task automatic test_random();
        logic [4:0] opcPick;
        $display("[TB] test_random");
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0:       opcPick = OPC_JAL_5;
                1:       opcPick = OPC_JALR_5;
                2:       opcPick = 5'($urandom);
                default: opcPick = OPC_BRANCH_5;
            endcase
            applyStimulus($urandom, $urandom, opcPick, 1'($urandom_range(0, 1)),
                          5'($urandom), 1'($urandom_range(0, 1)));
            for (int m = 0; m < 3; m++) begin
                numChecks++;
                if (predArr[m] !== expPredict(m) || idxArr[m] !== expIdx(m)) begin
                    numFails++;
                    $display("[TB] FAIL rand_pred[%0d] cyc %0d: got %b/%h expected %b/%h",
                             m, n, predArr[m], idxArr[m], expPredict(m), expIdx(m));
                end
                numChecks++;
                if (tgtArr[m] !== expTarget() || rdyArr[m] !== mReady) begin
                    numFails++;
                    $display("[TB] FAIL rand_tgt[%0d] cyc %0d: got %h/%b expected %h/%b",
                             m, n, tgtArr[m], rdyArr[m], expTarget(), mReady);
                end
            end
            stepClock();
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        $display("[TB] test_reset_mid");
        rst = 1'b0;
        applyStimulus(32'h0, 32'h0, OPC_BRANCH_5, 1'b1, 5'd7, 1'b1);
        stepClock();
        rst = 1'b1;
        numChecks++;
        if (rdyArr[1] !== 1'b0 || idxArr[0] !== 5'd0) begin
            numFails++;
            $display("[TB] FAIL mid_reset: got ready %b ghr %h expected 0/00", rdyArr[1], idxArr[0]);
        end
        repeat (10) begin
            applyStimulus(32'h0, 32'h0, OPC_BRANCH_5, 1'b1, 5'd7, 1'b1);
            stepClock();
        end
        rst = 1'b0;
        stepClock();
        rst    = 1'b1;
        cycles = 0;
        while (rdyArr[0] !== 1'b1 && cycles < 100) begin
            applyStimulus(32'h0, 32'h0, OPC_BRANCH_5, 1'b1, 5'($urandom), 1'b1);
            numChecks++;
            if (idxArr[0] !== 5'd0 || predArr[2] !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL init_upd_ignored: got ghr %h pred %b expected 00/0", idxArr[0], predArr[2]);
            end
            stepClock();
            cycles++;
        end
        numChecks++;
        if (cycles != 32) begin
            numFails++;
            $display("[TB] FAIL resweep_length: got %0d cycles expected 32", cycles);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(32'(i * 4), 32'h0, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
            numChecks++;
            if (predArr[2] !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL resweep_ctr%0d_lo: got %b expected 0", i, predArr[2]);
            end
            applyStimulus(32'(i * 4), 32'h0, OPC_BRANCH_5, 1'b1, 5'(i), 1'b1);
            stepClock();
            applyStimulus(32'(i * 4), 32'h0, OPC_BRANCH_5, 1'b0, 5'd0, 1'b0);
            numChecks++;
            if (predArr[2] !== 1'b1) begin
                numFails++;
                $display("[TB] FAIL resweep_ctr%0d_hi: got %b expected 1", i, predArr[2]);
            end
        end
    endtask

    task automatic test_target_wrap();
        $display("[TB] test_target_wrap");
        applyStimulus(32'hFFFF_FFF0, 32'h20, OPC_JAL_5, 1'b0, 5'd0, 1'b0);
        for (int m = 0; m < 3; m++) begin
            numChecks++;
            if (tgtArr[m] !== 32'h0000_0010 || predArr[m] !== 1'b1) begin
                numFails++;
                $display("[TB] FAIL wrap_jal[%0d]: got %h/%b expected 00000010/1", m, tgtArr[m], predArr[m]);
            end
        end
        applyStimulus(32'hFFFF_FFF0, 32'h20, OPC_JALR_5, 1'b0, 5'd0, 1'b0);
        for (int m = 0; m < 3; m++) begin
            numChecks++;
            if (predArr[m] !== 1'b0 || tgtArr[m] !== 32'h0000_0010) begin
                numFails++;
                $display("[TB] FAIL wrap_jalr[%0d]: got %b/%h expected 0/00000010", m, predArr[m], tgtArr[m]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mTable[i] = -1;
        mGhr   = 0;
        mPtr   = 0;
        mReady = 1'b0;
        rst    = 1'b0;
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_saturation();
        test_gshare_index();
        test_same_cycle();
        test_random();
        test_reset_mid();
        test_target_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
